// File: rtl/if_fetch.sv
// rtl/if_fetch.sv - instruction fetch stage with a 2-entry {pc, inst} buffer toward decode
// Optional IF_ALIGN_CHECK_EN: flag redirects whose target is not word aligned on misalign_o.
module if_fetch (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] rom_addr_o,
  output logic        rom_ce_o,
  input  logic [31:0] rom_data_i,
  input  logic        stall_i,
  input  logic        branch_flag_i,
  input  logic [31:0] branch_target_i,
  output logic        id_valid_o,
  input  logic        id_ready_i,
  output logic [31:0] id_pc_o,
  output logic [31:0] id_inst_o,
  output logic        misalign_o
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t      state;
  logic [31:0] pc;
  logic [1:0]  count;
  logic [31:0] pc0;
  logic [31:0] inst0;
  logic [31:0] pc1;
  logic [31:0] inst1;

  logic run;
  logic redirect;
  logic pop;
  logic push;

  assign run      = (state == RUN);
  assign redirect = run & branch_flag_i;
  // A redirect discards the head, so it is never counted as consumed.
  assign pop      = id_valid_o & id_ready_i & ~redirect;
  assign push     = run & ~stall_i & ~branch_flag_i & ((count != 2'd2) | pop);

  assign rom_ce_o   = run;
  assign rom_addr_o = run ? pc : 32'h0;

  assign id_valid_o = (count != 2'd0);
  assign id_pc_o    = id_valid_o ? pc0 : 32'h0;
  assign id_inst_o  = id_valid_o ? inst0 : 32'h0;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      pc    <= 32'h0;
      count <= 2'd0;
      pc0   <= 32'h0;
      inst0 <= 32'h0;
      pc1   <= 32'h0;
      inst1 <= 32'h0;
    end else begin
      state <= RUN;
      if (redirect) begin
        count <= 2'd0;
        pc    <= branch_target_i & ~32'h3;
      end else begin
        if (push) pc <= pc + 32'd4;
        count <= count + {1'b0, push} - {1'b0, pop};
        case ({push, pop})
          2'b10: begin
            if (count == 2'd0) begin
              pc0   <= pc;
              inst0 <= rom_data_i;
            end else begin
              pc1   <= pc;
              inst1 <= rom_data_i;
            end
          end
          2'b01: begin
            pc0   <= pc1;
            inst0 <= inst1;
          end
          2'b11: begin
            // With two entries the tail slides to the head and the new word takes the tail.
            if (count == 2'd2) begin
              pc0   <= pc1;
              inst0 <= inst1;
              pc1   <= pc;
              inst1 <= rom_data_i;
            end else begin
              pc0   <= pc;
              inst0 <= rom_data_i;
            end
          end
          default: ;
        endcase
      end
    end
  end

`ifdef IF_ALIGN_CHECK_EN
  logic misalign_q;

  always_ff @(posedge clk) begin
    if (!rst) misalign_q <= 1'b0;
    else      misalign_q <= redirect & (branch_target_i[1:0] != 2'b00);
  end

  assign misalign_o = misalign_q;
`else
  assign misalign_o = 1'b0;
`endif

endmodule

// File: tb/tb_if_fetch.sv
// tb/tb_if_fetch.sv - scoreboard bench for if_fetch with a queue-based reference model
module tb_if_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] rom_addr_o;
  logic        rom_ce_o;
  logic [31:0] rom_data_i;
  logic        stall_i;
  logic        branch_flag_i;
  logic [31:0] branch_target_i;
  logic        id_valid_o;
  logic        id_ready_i;
  logic [31:0] id_pc_o;
  logic [31:0] id_inst_o;
  logic        misalign_o;

  logic        rom_mode;
  logic [31:0] rnd_word;

`ifdef IF_ALIGN_CHECK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } ent_t;

  ent_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  logic [31:0] m_pc  = 32'h0;
  bit          m_run = 1'b0;
  bit          m_mis = 1'b0;
  int          m_cnt = 0;

  if_fetch dut (
    .clk            (clk),
    .rst            (rst),
    .rom_addr_o     (rom_addr_o),
    .rom_ce_o       (rom_ce_o),
    .rom_data_i     (rom_data_i),
    .stall_i        (stall_i),
    .branch_flag_i  (branch_flag_i),
    .branch_target_i(branch_target_i),
    .id_valid_o     (id_valid_o),
    .id_ready_i     (id_ready_i),
    .id_pc_o        (id_pc_o),
    .id_inst_o      (id_inst_o),
    .misalign_o     (misalign_o)
  );

  always #5 clk = ~clk;

  // ROM either returns its own address or a per-cycle random word.
  assign rom_data_i = rom_mode ? rnd_word : (rom_ce_o ? rom_addr_o : 32'h0);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step(input logic r, input logic s, input logic b,
                      input logic [31:0] t, input logic rd);
    @(posedge clk);
    #1;
    rst             = r;
    stall_i         = s;
    branch_flag_i   = b;
    branch_target_i = t;
    id_ready_i      = rd;
    rnd_word        = $urandom;
  endtask

  // Reference model: per-cycle output checks, then commit the next edge's effect.
  initial begin
    logic [31:0] word;
    bit          popm;
    forever begin
      @(negedge clk);
      #2;
      chk("rom_ce", {31'h0, rom_ce_o}, {31'h0, m_run});
      chk("rom_addr", rom_addr_o, m_run ? m_pc : 32'h0);
      chk("id_valid", {31'h0, id_valid_o}, {31'h0, m_cnt != 0});
      chk("misalign", {31'h0, misalign_o}, {31'h0, m_mis});
      if (m_cnt == 0) begin
        chk("id_pc_empty", id_pc_o, 32'h0);
        chk("id_inst_empty", id_inst_o, 32'h0);
      end
      word = rom_mode ? rnd_word : m_pc;
      if (!rst) begin
        m_pc  = 32'h0;
        m_run = 1'b0;
        m_cnt = 0;
        m_mis = 1'b0;
        exp_q.delete();
      end else if (!m_run) begin
        m_run = 1'b1;
        m_mis = 1'b0;
      end else if (branch_flag_i) begin
        exp_q.delete();
        m_cnt = 0;
        m_pc  = {branch_target_i[31:2], 2'b00};
        m_mis = ALIGN && (branch_target_i[1:0] != 2'b00);
      end else begin
        m_mis = 1'b0;
        popm  = (m_cnt != 0) && id_ready_i;
        if (!stall_i && (m_cnt < 2 || popm)) begin
          exp_q.push_back('{pc: m_pc, inst: word});
          m_cnt++;
          m_pc = m_pc + 32'd4;
        end
        if (popm) m_cnt--;
      end
    end
  end

  // Monitor: every accepted head must match the oldest expected fetch.
  initial begin
    ent_t e;
    forever begin
      @(negedge clk);
      #1;
      if (rst && id_valid_o && id_ready_i && !branch_flag_i) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL sb_empty: got pc %h with no expected entry", id_pc_o);
        end else begin
          e = exp_q.pop_front();
          chk("sb_pc", id_pc_o, e.pc);
          chk("sb_inst", id_inst_o, e.inst);
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst             = 1'b0;
    stall_i         = 1'b0;
    branch_flag_i   = 1'b0;
    branch_target_i = 32'h0;
    id_ready_i      = 1'b0;
    rom_mode        = 1'b0;
    rnd_word        = 32'h0;

    // Reset release with decode always ready: 0x0, 0x4, 0x8 stream out.
    repeat (3) step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    chk("rst_ce", {31'h0, rom_ce_o}, 32'h0);
    chk("rst_valid", {31'h0, id_valid_o}, 32'h0);
    step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
    chk("idle_ce", {31'h0, rom_ce_o}, 32'h0);
    step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
    chk("first_addr", rom_addr_o, 32'h0);
    chk("first_ce", {31'h0, rom_ce_o}, 32'h1);
    step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
    chk("inst0", id_inst_o, 32'h0);
    step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
    chk("inst1", id_inst_o, 32'h4);
    step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
    chk("inst2", id_inst_o, 32'h8);

    // Decode not ready for 5 cycles: buffer fills with 0x0, 0x4, PC holds 0x8.
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    repeat (5) step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    chk("full_addr", rom_addr_o, 32'h8);
    chk("full_ce", {31'h0, rom_ce_o}, 32'h1);
    chk("full_head", id_pc_o, 32'h0);

    // Redirect while full.
    step(1'b1, 1'b0, 1'b1, 32'h100, 1'b0);
    chk("redir_shown", {31'h0, id_valid_o}, 32'h1);
    step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    chk("redir_flush", {31'h0, id_valid_o}, 32'h0);
    step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
    chk("redir_pc", id_pc_o, 32'h100);

    // Stall with one entry: head drains, PC frozen.
    step(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
    chk("stall_addr", rom_addr_o, 32'h108);
    step(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
    chk("stall_empty1", {31'h0, id_valid_o}, 32'h0);
    step(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
    chk("stall_empty2", {31'h0, id_valid_o}, 32'h0);
    chk("stall_addr2", rom_addr_o, 32'h108);

    // Misaligned redirect.
    step(1'b1, 1'b0, 1'b1, 32'h102, 1'b1);
    step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
    chk("mis_pulse", {31'h0, misalign_o}, {31'h0, ALIGN});
    chk("mis_addr", rom_addr_o, 32'h100);
    step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    chk("mis_clear", {31'h0, misalign_o}, 32'h0);
    chk("mis_pc", id_pc_o, 32'h100);

    // Reset together with a redirect while full.
    step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    chk("pre_rst_valid", {31'h0, id_valid_o}, 32'h1);
    step(1'b0, 1'b0, 1'b1, 32'h200, 1'b0);
    step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
    chk("rst_mid_valid", {31'h0, id_valid_o}, 32'h0);
    chk("rst_mid_ce", {31'h0, rom_ce_o}, 32'h0);
    chk("rst_mid_addr", rom_addr_o, 32'h0);

    // Randomised traffic with arbitrary ROM words and wrap-prone targets.
    rom_mode = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] tgt;
      tgt = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF)) : $urandom;
      step($urandom_range(0, 99) >= 2,
           $urandom_range(0, 99) < 20,
           $urandom_range(0, 99) < 8,
           tgt,
           $urandom_range(0, 99) < 60);
    end
    step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
    @(negedge clk);
    #3;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/if_fetch.md
IF_FETCH -- requirements
Module: if_fetch

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, all state updates on rising edge.
REQ-002 SHALL have: rst  in  1  reset, synchronous, active-low (0 = reset).
REQ-003 SHALL have: rom_addr_o  out  32  byte address to instruction ROM.
REQ-004 SHALL have: rom_ce_o  out  1  ROM chip enable (1 = enable, 0 = ROM returns zero word).
REQ-005 SHALL have: rom_data_i  in  32  instruction word, valid combinationally in the same cycle as rom_addr_o.
REQ-006 SHALL have: stall_i  in  1  freeze fetch issue (pipeline ctrl).
REQ-007 SHALL have: branch_flag_i  in  1  redirect request.
REQ-008 SHALL have: branch_target_i  in  32  redirect byte address.
REQ-009 SHALL have: id_valid_o  out  1  buffer head holds an instruction.
REQ-010 SHALL have: id_ready_i  in  1  decode accepts the head this cycle.
REQ-011 SHALL have: id_pc_o  out  32  PC of head entry.
REQ-012 SHALL have: id_inst_o  out  32  instruction of head entry.
REQ-013 SHALL have: misalign_o  out  1  misaligned redirect flag (REQ-032).

Function
REQ-014 SHALL hold a 32-bit fetch PC and a 2-entry FIFO of {pc, inst} pairs with a 2-bit count (0..2).
REQ-015 SHALL drive rom_addr_o = PC and rom_ce_o = 1 only in state RUN; otherwise rom_ce_o = 0.
REQ-016 SHALL use states: IDLE (in reset / first cycle after reset) -> RUN (unconditionally next cycle); no other transitions except reset to IDLE.
REQ-017 Issue condition: RUN, stall_i = 0, branch_flag_i = 0, and (count < 2 or pop this cycle).
REQ-018 On issue SHALL push {PC, rom_data_i} at the clock edge and set PC <= PC + 4 (mod 2^32, 0xFFFFFFFC wraps to 0x00000000).
REQ-019 Pop SHALL occur when id_valid_o = 1 and id_ready_i = 1; head advances at the edge.
REQ-020 Simultaneous push and pop SHALL leave count unchanged; push on full without pop SHALL never happen.
REQ-021 id_valid_o SHALL equal (count != 0); id_pc_o/id_inst_o SHALL present the head entry, zero when empty.
REQ-022 Fetch latency: instruction at PC appears at id_*_o one cycle after its issue cycle.
REQ-023 branch_flag_i = 1 (any state RUN) SHALL at the edge: clear the FIFO (count <= 0), suppress push, set PC <= target with bits [1:0] cleared; priority over stall_i and any pop.
REQ-024 During redirect cycle, the current head may still be shown but SHALL be discarded regardless of id_ready_i.
REQ-025 stall_i = 1 SHALL hold PC and suppress push; pops SHALL continue.
REQ-026 rom_data_i SHALL be sampled only in issue cycles; its value at other times SHALL not affect state.

Reset
REQ-027 While rst = 0 at an edge: PC <= 0x00000000, count <= 0, state <= IDLE, misalign_o <= 0, FIFO contents <= 0.
REQ-028 Outputs during/after reset: rom_ce_o = 0, rom_addr_o = 0, id_valid_o = 0, id_pc_o = 0, id_inst_o = 0.
REQ-029 Reset asserted mid-operation SHALL discard all buffered entries and any concurrent redirect, with no push that edge.
REQ-030 First issue after reset release SHALL be at address 0x00000000 on the second cycle with rst = 1.

Configuration
REQ-031 Macro IF_ALIGN_CHECK_EN SHALL gate misaligned-redirect detection.
REQ-032 With IF_ALIGN_CHECK_EN defined: redirect with branch_target_i[1:0] != 0 SHALL register misalign_o = 1 for exactly one cycle after the redirect edge; redirect still performed per REQ-023.
REQ-033 Without IF_ALIGN_CHECK_EN: misalign_o SHALL be constant 0; low bits silently cleared.

Verification
REQ-034 Reset release, id_ready_i = 1, ROM word = address: rom_ce_o low 1 cycle, then id_inst_o = 0x0, 0x4, 0x8 on consecutive cycles.
REQ-035 id_ready_i = 0 for 5 cycles: exactly 2 pushes (PC 0x0, 0x4), count = 2, PC holds 0x8, rom_ce_o stays 1.
REQ-036 FIFO full, branch_flag_i = 1, target 0x100: next cycle id_valid_o = 0, then id_pc_o = 0x100.
REQ-037 stall_i = 1 for 3 cycles with count = 1, id_ready_i = 1: head popped, PC unchanged, id_valid_o = 0 during remaining stall.
REQ-038 Target 0x102 with IF_ALIGN_CHECK_EN: misalign_o pulses 1 cycle, next fetch at 0x100; without macro misalign_o stays 0.
REQ-039 rst = 0 while count = 2 and branch_flag_i = 1: next cycle count = 0, PC = 0x0, rom_ce_o = 0.
